alu_out_stage: RTL

- Output staging block directly downstream of the ALU execution units (arithmetic, logic, compare, shift).
- Each cycle it collects the registered result of whichever unit raised its flag, tags the result with a unit ID, and buffers it in a DEPTH-entry FIFO.
- Results are delivered to the consumer over a valid/ready handshake.
- Detects and reports lost results (overflow) and multiple simultaneous unit flags (conflict).

---
 rtl/alu_out_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_out_stage.sv
// Purpose  : collects the flagged ALU unit result, tags it with its unit ID and queues it in a DEPTH-entry FIFO.
// Latency  : 1 cycle from a sampled flag to out_valid/head data; no combinational bypass.
// Backpress: valid/ready toward the consumer; a push into a full FIFO with no pop is dropped and ovf_err is set.
//
// Ports:
//   clock, rest                   - system clock, asynchronous active-high reset
//   {arith,logic,cmp,shift}_out   - registered unit results (WIDTH bits)
//   {arith,logic,cmp,shift}_flag  - unit result valid this cycle
//   out_ready                     - consumer takes the head entry when out_valid is high
//   err_clr                       - clears the sticky error flags (a new set condition wins)
//   out_data, out_unit, out_valid - head entry (0 when empty); unit 0=arith 1=logic 2=cmp 3=shift
//   fifo_level, full              - occupancy and full indication
//   ovf_err, conflict_err         - sticky: result dropped / several flags in one cycle
//   result_cnt                    - only when ALU_OUT_STAT_EN is defined: count of accepted pops, wraps at 16 bits
//
// Build option: define ALU_OUT_STAT_EN to add the result_cnt output and its counter.

module alu_out_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     rest,
  input  logic [WIDTH-1:0]         arith_out,
  input  logic                     arith_flag,
  input  logic [WIDTH-1:0]         logic_out,
  input  logic                     logic_flag,
  input  logic [WIDTH-1:0]         cmp_out,
  input  logic                     cmp_flag,
  input  logic [WIDTH-1:0]         shift_out,
  input  logic                     shift_flag,
  input  logic                     out_ready,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         out_data,
  output logic [1:0]               out_unit,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     full,
  output logic                     ovf_err,
`ifdef ALU_OUT_STAT_EN
  output logic [15:0]              result_cnt,
`endif
  output logic                     conflict_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [1:0]       unit;
    logic [WIDTH-1:0] dat;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [3:0]      flags;
  entry_t          sel;
  logic            push;
  logic            pop;
  logic            push_acc;
  logic            ovf_set;
  logic            conflict;

  assign flags = {shift_flag, cmp_flag, logic_flag, arith_flag};
  assign push  = |flags;

  // Clearing the lowest set bit leaves something only if two or more flags are high.
  assign conflict = |(flags & (flags - 4'd1));

  // Fixed priority arith > logic > cmp > shift.
  always_comb begin
    sel = '0;
    if (arith_flag) begin
      sel.unit = 2'd0;
      sel.dat  = arith_out;
    end else if (logic_flag) begin
      sel.unit = 2'd1;
      sel.dat  = logic_out;
    end else if (cmp_flag) begin
      sel.unit = 2'd2;
      sel.dat  = cmp_out;
    end else if (shift_flag) begin
      sel.unit = 2'd3;
      sel.dat  = shift_out;
    end
  end

  assign out_valid = (fifo_level != '0);
  assign full      = (fifo_level == LW'(DEPTH));
  assign pop       = out_valid & out_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
  assign push_acc  = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;

  // Head is forced to zero when empty so stale storage never leaks to the consumer.
  assign out_data = out_valid ? mem[rd_ptr].dat  : '0;
  assign out_unit = out_valid ? mem[rd_ptr].unit : 2'd0;

  // Storage needs no reset; only pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (push_acc) begin
      mem[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge clock or posedge rest) begin
    if (rest) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_acc, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky errors: a set condition in the same cycle as err_clr keeps the flag high.
  always_ff @(posedge clock or posedge rest) begin
    if (rest) begin
      ovf_err      <= 1'b0;
      conflict_err <= 1'b0;
    end else begin
      ovf_err      <= ovf_set  | (ovf_err      & ~err_clr);
      conflict_err <= conflict | (conflict_err & ~err_clr);
    end
  end

`ifdef ALU_OUT_STAT_EN
  always_ff @(posedge clock or posedge rest) begin
    if (rest) begin
      result_cnt <= '0;
    end else if (pop) begin
      result_cnt <= result_cnt + 16'd1;
    end
  end
`endif

endmodule
